i2s_transmitter: RTL and testbench
==================================

I2S_TRANSMITTER -- requirements
Module: i2s_transmitter

Interface
REQ-001 SHALL have parameter SCLK_HALF_PERIOD, default 16, giving clk_in cycles per sclk half-period (legal ≥2); default gives a 3.125 MHz sclk from 100 MHz.
REQ-002 SHALL have port clk_in, input, 1 bit: the single clock of the block.
REQ-003 SHALL have port rst_in, input, 1 bit: the reset, which is asynchronous and active-high.
REQ-004 SHALL have port left_in, input, 16 bits: the signed left sample.
REQ-005 SHALL have port right_in, input, 16 bits: the signed right sample.
REQ-006 SHALL have port valid_in, input, 1 bit: left_in and right_in are valid.
REQ-007 SHALL have port ready_out, output, 1 bit: the holding register can accept a sample pair.
REQ-008 SHALL have port sclk_out, output, 1 bit: the I2S bit clock.
REQ-009 SHALL have port ws_out, output, 1 bit: the I2S word select (0 = left, 1 = right).
REQ-010 SHALL have port sdata_out, output, 1 bit: the I2S serial data.
REQ-011 SHALL have port underrun_out, output, 1 bit: one-cycle pulse when a frame starts with no new sample.

Function
REQ-012 SHALL drive all outputs directly from registers (no combinational paths from inputs to outputs).
REQ-013 SHALL toggle sclk_out when the divider counter reaches SCLK_HALF_PERIOD-1, then wrap the counter to 0.
REQ-014 SHALL define a "fall" event as a divider wrap while sclk_out=1.
REQ-015 SHALL update the 6-bit slot counter, ws_out and sdata_out only on fall events, on the same clk_in edge that drives sclk_out low.
REQ-016 SHALL increment the slot counter (0..63, wrap 63→0) on each fall event.
REQ-017 SHALL set ws_out to 0 for slots 0..31 and to 1 for slots 32..63.
REQ-018 SHALL drive sdata_out for slot s as: left[16-s] for s=1..16; right[48-s] for s=33..48; 0 for all other slots (Philips I2S format, one-bit delay, MSB first, 32-bit slots).
REQ-019 SHALL load the frame register from the holding register on the fall event entering slot 0.
REQ-020 SHALL, when the holding register is full at that fall event, mark it empty after the load.
REQ-021 SHALL, when the holding register is empty at that fall event, keep the frame register unchanged (repeat the last pair) and pulse underrun_out for exactly one clk_in cycle.
REQ-022 SHALL drive ready_out as the registered inverse of the holding-register-full flag.
REQ-023 SHALL accept a pair (capture it and set full) in any cycle where valid_in=1 and ready_out=1.
REQ-024 SHALL not bypass an accept into the frame register: an accept in the same cycle as the slot-0 load still counts as an underrun if the holding register was empty, and the accepted pair is used for the next frame.
REQ-025 SHALL ignore valid_in while ready_out=0 (no overwrite).
REQ-026 SHALL have a latency of at most one frame plus 2 sclk periods from accept to the MSB on sdata_out.
REQ-027 SHALL have a frame period of 128*SCLK_HALF_PERIOD clk_in cycles (2048 cycles at the default).

Reset
REQ-028 SHALL, while rst_in=1 (asynchronously), force: sclk_out=0, ws_out=1, sdata_out=0, underrun_out=0, ready_out=1, divider=0, slot counter=63, holding register empty, frame register zero.
REQ-029 SHALL make the first fall event after reset enter slot 0 and load the frame register (or signal underrun).
REQ-030 SHALL, on reset mid-frame, abandon the frame immediately; no partial state persists.

Structure
REQ-031 SHALL take SAMPLE_WIDTH=16, SLOT_BITS=32 and FRAME_SLOTS=64 from the shared package i2s_pkg, also used by i2s_receiver.
REQ-032 SHALL place the divider and fall/rise strobes in sub-module i2s_sclk_gen (parameter SCLK_HALF_PERIOD; outputs sclk and fall strobe).

Verification
REQ-033 SHALL verify reset: hold rst_in 5 cycles, release → sclk_out first rises at cycle 16, first fall at cycle 32 with ws_out 1→0 and underrun_out pulsing once.
REQ-034 SHALL verify basic transfer: accept left=16'hA5C3, right=16'h8001 before a slot-0 fall → next frame shows left MSB at slot 1, LSB at slot 16, zeros at 17..32, right 1000...0001 at slots 33..48, zeros after.
REQ-035 SHALL verify backpressure: drive valid_in continuously with distinct pairs → ready_out low after each accept and high after each slot-0 load; exactly one pair per frame; no pair lost or duplicated; underrun_out stays 0.
REQ-036 SHALL verify underrun: stop valid_in after pair 16'h1234/16'h5678 → the next frame repeats 1234/5678 and underrun_out pulses one cycle at each slot-0 fall.
REQ-037 SHALL verify simultaneity: assert valid_in in the exact slot-0 load cycle with the holding register empty → underrun pulses, and the pair appears in the following frame.
REQ-038 SHALL verify mid-frame reset: assert rst_in at slot 40 → all outputs go to reset values within the same cycle, and the next frame restarts cleanly at slot 0.

Source files
------------

// File: rtl/i2s_pkg.sv
// Shared I2S definitions: frame geometry, sample pair type and the
// slot-to-bit mapping of the Philips format. Also used by i2s_receiver.
package i2s_pkg;

  localparam int SAMPLE_WIDTH = 16;
  localparam int SLOT_BITS    = 32;
  localparam int FRAME_SLOTS  = 64;
  localparam int SLOT_W       = $clog2(FRAME_SLOTS);
  localparam int SAMPLE_IDX_W = $clog2(SAMPLE_WIDTH);

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [SLOT_W-1:0]       slot_t;

  typedef struct packed {
    sample_t left;
    sample_t right;
  } pair_t;

  localparam slot_t LAST_SLOT = slot_t'(FRAME_SLOTS - 1);
  localparam slot_t HALF_SLOT = slot_t'(FRAME_SLOTS / 2);

  // Serial bit for a slot: one-bit delay after the word-select edge, MSB
  // first, samples padded with zeros to fill each 32-slot half.
  function automatic logic slot_bit(input pair_t p, input slot_t s);
    int   idx;
    logic bit_v;
    bit_v = 1'b0;
    idx   = 0;
    if (int'(s) >= 1 && int'(s) <= SAMPLE_WIDTH) begin
      idx   = SAMPLE_WIDTH - int'(s);
      bit_v = p.left[idx[SAMPLE_IDX_W-1:0]];
    end else if (int'(s) >= SLOT_BITS + 1 && int'(s) <= SLOT_BITS + SAMPLE_WIDTH) begin
      idx   = SLOT_BITS + SAMPLE_WIDTH - int'(s);
      bit_v = p.right[idx[SAMPLE_IDX_W-1:0]];
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/i2s_transmitter_if.sv
// Sample-pair input handshake and I2S line outputs of the transmitter.
interface i2s_transmitter_if;
  import i2s_pkg::*;

  // Handshake: a pair (left_in, right_in) transfers on every clk_in rising
  // edge where valid_in && ready_out. The source holds data stable while
  // valid_in is high and not yet accepted; valid_in while ready_out is low
  // is ignored. ready_out does not depend combinationally on valid_in.
  sample_t left_in;
  sample_t right_in;
  logic    valid_in;
  logic    ready_out;
  logic    sclk_out;
  logic    ws_out;
  logic    sdata_out;
  logic    underrun_out;
  slot_t   slot_dbg;

  modport master (
    output left_in, right_in, valid_in,
    input  ready_out, sclk_out, ws_out, sdata_out, underrun_out, slot_dbg
  );

  modport slave (
    input  left_in, right_in, valid_in,
    output ready_out, sclk_out, ws_out, sdata_out, underrun_out, slot_dbg
  );

endinterface

// File: rtl/i2s_sclk_gen.sv
// Bit-clock divider: toggles sclk every SCLK_HALF_PERIOD clk_in cycles
// (legal values are 2 and above) and flags the cycle that drives sclk low.
module i2s_sclk_gen #(
  parameter int SCLK_HALF_PERIOD = 16
) (
  input  logic clk_in,
  input  logic rst_in,
  output logic sclk,
  output logic fall
);

  localparam int CNT_W = (SCLK_HALF_PERIOD > 2) ? $clog2(SCLK_HALF_PERIOD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCLK_HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;
  logic             wrap;

  assign wrap = (cnt == CNT_LAST);
  // The wrap that takes sclk from 1 to 0 is the only edge the data path acts on.
  assign fall = wrap & sclk;

  // Half-period counter and the bit-clock register it toggles.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt  <= '0;
      sclk <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      sclk <= ~sclk;
    end else begin
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/i2s_transmitter.sv
// I2S (Philips) transmitter: one-deep holding register in front of a frame
// register, 64-slot frame, underrun flagged when a frame starts with no new
// pair (the previous pair is then repeated).
module i2s_transmitter
  import i2s_pkg::*;
#(
  parameter int SCLK_HALF_PERIOD = 16
) (
  input logic clk_in,
  input logic rst_in,
  i2s_transmitter_if.slave bus
);

  logic  sclk;
  logic  fall;
  slot_t slot;
  slot_t slot_next;
  pair_t hold_reg;
  pair_t frame_reg;
  pair_t frame_next;
  logic  hold_full;
  logic  full_next;
  logic  accept;
  logic  load_slot0;

  i2s_sclk_gen #(
    .SCLK_HALF_PERIOD(SCLK_HALF_PERIOD)
  ) u_sclk_gen (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .sclk  (sclk),
    .fall  (fall)
  );

  assign bus.sclk_out = sclk;
  assign bus.slot_dbg = slot;

  assign slot_next  = slot + 1'b1;
  assign accept     = bus.valid_in & bus.ready_out;
  assign load_slot0 = fall & (slot_next == '0);

  // Frame contents seen by the slot being entered; a same-cycle accept
  // never bypasses into the frame, it waits for the next slot-0 load.
  always_comb begin
    frame_next = frame_reg;
    full_next  = hold_full;
    if (load_slot0 && hold_full) begin
      frame_next = hold_reg;
      full_next  = 1'b0;
    end
    if (accept) begin
      full_next = 1'b1;
    end
  end

  // Slot sequencing, serial data, holding register and registered flags.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      slot             <= LAST_SLOT;
      bus.ws_out       <= 1'b1;
      bus.sdata_out    <= 1'b0;
      bus.underrun_out <= 1'b0;
      bus.ready_out    <= 1'b1;
      hold_full        <= 1'b0;
      hold_reg         <= '0;
      frame_reg        <= '0;
    end else begin
      bus.underrun_out <= 1'b0;
      if (fall) begin
        slot          <= slot_next;
        bus.ws_out    <= (slot_next >= HALF_SLOT);
        bus.sdata_out <= slot_bit(frame_next, slot_next);
      end
      if (load_slot0) begin
        frame_reg <= frame_next;
        if (!hold_full) begin
          bus.underrun_out <= 1'b1;
        end
      end
      if (accept) begin
        hold_reg <= '{left: bus.left_in, right: bus.right_in};
      end
      hold_full     <= full_next;
      bus.ready_out <= ~full_next;
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Testbench for i2s_transmitter: cycle-level reference model from the frame
// arithmetic, per-cycle output checks, and an I2S receiver monitor that
// deserialises each frame and compares it against the expected pair queue.
module tb_i2s_transmitter;
  import i2s_pkg::*;

  localparam int HP      = 16;
  localparam int FALL_P  = 2 * HP;
  localparam int FRAME_P = 128 * HP;

  // ---------------- clock / reset ----------------
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  always #5 clk_in = ~clk_in;

  i2s_transmitter_if bus();

  i2s_transmitter #(.SCLK_HALF_PERIOD(HP)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];        // pairs accepted, not yet in a frame
  logic [31:0] frame_exp_q[$];  // pair each started frame must carry
  logic [31:0] cur;
  int          cyc;
  logic        e_sclk, e_ws, e_sdata, e_under, e_ready;
  int          vectors = 0;
  int          miscompares = 0;
  int          rx_frames = 0;

  task automatic check1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t cyc=%0d: got %b want %b", name, $time, cyc, act, exp);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s t=%0t cyc=%0d: got %h want %h", name, $time, cyc, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s t=%0t cyc=%0d: bound expired or nothing expected", name, $time, cyc);
  endtask

  // Serial bit of a pair {left,right} for slot s, straight from the format rules.
  function automatic logic exp_bit(input logic [31:0] p, input int s);
    logic [4:0] idx;
    idx = '0;
    if (s >= 1 && s <= 16) begin
      idx = 5'(32 - s);
      return p[idx];
    end
    if (s >= 33 && s <= 48) begin
      idx = 5'(48 - s);
      return p[idx];
    end
    return 1'b0;
  endfunction

  // ---------------- reference model ----------------
  always @(posedge clk_in or posedge rst_in) begin : model
    logic acc;
    int   f;
    int   slot;
    if (rst_in) begin
      cyc = 0;
      exp_q.delete();
      frame_exp_q.delete();
      cur     = '0;
      e_sclk  = 1'b0;
      e_ws    = 1'b1;
      e_sdata = 1'b0;
      e_under = 1'b0;
      e_ready = 1'b1;
    end else begin
      acc  = bus.valid_in && (exp_q.size() == 0);
      cyc++;
      f    = cyc / FALL_P;
      slot = (f == 0) ? 63 : (f - 1) % 64;
      e_under = 1'b0;
      if ((cyc % FALL_P) == 0 && slot == 0) begin
        if (exp_q.size() > 0) cur = exp_q.pop_front();
        else e_under = 1'b1;
        frame_exp_q.push_back(cur);
      end
      if (acc) exp_q.push_back({bus.left_in, bus.right_in});
      e_sclk  = ((cyc / HP) % 2) == 1;
      e_ws    = (slot >= 32);
      e_sdata = exp_bit(cur, slot);
      e_ready = (exp_q.size() == 0);
    end
  end

  // ---------------- per-cycle output monitor ----------------
  always @(negedge clk_in) begin
    check1("sclk_out", bus.sclk_out, e_sclk);
    check1("ws_out", bus.ws_out, e_ws);
    check1("sdata_out", bus.sdata_out, e_sdata);
    check1("underrun_out", bus.underrun_out, e_under);
    check1("ready_out", bus.ready_out, e_ready);
  end

  // ---------------- I2S receiver monitor ----------------
  logic rx_prev_sclk, rx_prev_ws, rx_active;
  int   rx_slot;
  logic rx_bits [64];

  always @(negedge clk_in) begin : rx_mon
    logic [31:0] got;
    logic        extra;
    if (rst_in) begin
      rx_prev_sclk = 1'b0;
      rx_prev_ws   = 1'b1;
      rx_active    = 1'b0;
      rx_slot      = 0;
    end else begin
      if (bus.sclk_out && !rx_prev_sclk) begin
        if (!bus.ws_out && rx_prev_ws) begin
          rx_active = 1'b1;
          rx_slot   = 0;
        end else begin
          rx_slot++;
        end
        rx_prev_ws = bus.ws_out;
        if (rx_active && rx_slot < 64) begin
          rx_bits[rx_slot] = bus.sdata_out;
          if (rx_slot == 63) begin
            got   = '0;
            extra = 1'b0;
            for (int i = 0; i < 16; i++) begin
              got[31-i] = rx_bits[1+i];
              got[15-i] = rx_bits[33+i];
            end
            for (int i = 0; i < 64; i++)
              if (!((i >= 1 && i <= 16) || (i >= 33 && i <= 48))) extra |= rx_bits[i];
            if (frame_exp_q.size() == 0) begin
              fail_now("rx_frame_unexpected");
            end else begin
              check32("rx_pair", got, frame_exp_q.pop_front());
              check1("rx_pad_zero", extra, 1'b0);
              rx_frames++;
            end
            rx_active = 1'b0;
          end
        end
      end
      rx_prev_sclk = bus.sclk_out;
    end
  end

  // ---------------- driver tasks ----------------
  // Presents a pair from a negedge and returns at the negedge after it was taken.
  task automatic send_pair(input logic [15:0] l, input logic [15:0] r);
    int guard;
    guard = 0;
    bus.left_in  = l;
    bus.right_in = r;
    bus.valid_in = 1'b1;
    while (!bus.ready_out && guard < 3 * FRAME_P) begin
      @(negedge clk_in);
      guard++;
    end
    if (guard >= 3 * FRAME_P) fail_now("send_timeout");
    @(negedge clk_in);
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    repeat (n) @(negedge clk_in);
  endtask

  task automatic wait_cyc(input int t);
    int guard;
    guard = 0;
    while (cyc < t && guard < 4 * FRAME_P) begin
      @(negedge clk_in);
      guard++;
    end
    if (cyc != t) fail_now("wait_cyc");
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t: simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    int f;
    int t;
    bus.valid_in = 1'b0;
    bus.left_in  = '0;
    bus.right_in = '0;
    rst_in       = 1'b1;
    repeat (5) @(negedge clk_in);
    rst_in = 1'b0;

    // Reset release: first rise at 16, first fall at 32 enters slot 0 with underrun.
    wait_cyc(15);
    check1("rst_sclk_low_15", bus.sclk_out, 1'b0);
    wait_cyc(16);
    check1("rst_sclk_rise_16", bus.sclk_out, 1'b1);
    wait_cyc(31);
    check1("rst_ws_31", bus.ws_out, 1'b1);
    check1("rst_under_31", bus.underrun_out, 1'b0);
    wait_cyc(32);
    check1("rst_ws_fall_32", bus.ws_out, 1'b0);
    check1("rst_sclk_fall_32", bus.sclk_out, 1'b0);
    check1("rst_under_32", bus.underrun_out, 1'b1);
    wait_cyc(33);
    check1("rst_under_33", bus.underrun_out, 1'b0);

    // Basic transfer.
    send_pair(16'hA5C3, 16'h8001);
    check1("basic_ready_low", bus.ready_out, 1'b0);
    idle(0);
    wait_cyc(FALL_P + 2 * FRAME_P + 100);

    // Backpressure: continuous valid, distinct pairs.
    for (int k = 0; k < 5; k++) send_pair(16'(k * 16'h1111 + 16'h0F0F), 16'($urandom));
    idle(10);

    // Underrun: last pair repeats.
    send_pair(16'h1234, 16'h5678);
    idle(3 * FRAME_P);

    // Simultaneity: valid only in the exact slot-0 load cycle.
    f = cyc / FALL_P + 2;
    while (((f - 1) % 64) != 0) f++;
    wait_cyc(f * FALL_P - 1);
    check1("sim_ready_before", bus.ready_out, 1'b1);
    bus.left_in  = 16'hBEEF;
    bus.right_in = 16'hCAFE;
    bus.valid_in = 1'b1;
    @(negedge clk_in);
    bus.valid_in = 1'b0;
    check1("sim_underrun", bus.underrun_out, 1'b1);
    check1("sim_ready_after", bus.ready_out, 1'b0);
    idle(2 * FRAME_P);

    // Randomised gaps and data.
    for (int k = 0; k < 8; k++) begin
      idle($urandom_range(0, 2500));
      send_pair(16'($urandom), 16'($urandom));
    end
    idle(100);

    // Mid-frame reset at slot 40.
    f = cyc / FALL_P + 2;
    while (((f - 1) % 64) != 40) f++;
    t = f * FALL_P;
    wait_cyc(t);
    @(posedge clk_in);
    #2 rst_in = 1'b1;
    #1;
    check1("mrst_sclk", bus.sclk_out, 1'b0);
    check1("mrst_ws", bus.ws_out, 1'b1);
    check1("mrst_sdata", bus.sdata_out, 1'b0);
    check1("mrst_under", bus.underrun_out, 1'b0);
    check1("mrst_ready", bus.ready_out, 1'b1);
    check32("mrst_slot", 32'(bus.slot_dbg), 32'd63);
    repeat (3) @(negedge clk_in);
    rst_in = 1'b0;
    send_pair(16'h7E81, 16'h0240);
    idle(FALL_P + 2 * FRAME_P + 100);

    check1("rx_frame_count", rx_frames >= 10, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
